// File: rtl/scanout_pkg.sv
// Shared types for the frame scanout block: controller states and the
// dimension / pixel-index widths used by the frame buffer programming.
package scanout_pkg;

    localparam int DIM_W = 12;
    localparam int IDX_W = 24;

    typedef logic [DIM_W-1:0] dim_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous pixel FIFO with fall-through head: dout always shows the oldest
// entry. A push while full is accepted only together with a pop.
module scanout_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; validity lives only in
    // the pointers and count, so a reset never has to touch the array.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: every register here uses <= so all updates see pre-edge values,
    // which is what keeps count and the pointers consistent with each other.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// Streams a row-major frame buffer out of memory as a valid/ready pixel stream.
// Define FRAME_SCANOUT_LOOP_EN for continuous refresh (frames restart until reset).
module frame_scanout
    import scanout_pkg::*;
#(
    parameter int DATA_WIDTH      = 24,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] frameAddress,
    input  logic [DIM_W-1:0]         width,
    input  logic [DIM_W-1:0]         height,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] readAddress,
    output logic                     readValid,
    input  logic                     readReady,
    input  logic [DATA_WIDTH-1:0]    readData,
    input  logic                     readDataValid,
    output logic [DATA_WIDTH-1:0]    pixel,
    output logic                     pixelValid,
    input  logic                     pixelReady,
    output logic                     pixelFirst,
    output logic                     pixelLast
);

`ifdef FRAME_SCANOUT_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CRED_W = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

    state_t                   state;
    state_t                   next_state;
    logic [ADDRESS_WIDTH-1:0] base_q;
    dim_t                     width_q;
    dim_t                     height_q;
    idx_t                     total_q;
    idx_t                     req_idx;
    dim_t                     col;
    dim_t                     row;
    logic [OUT_W-1:0]         outstanding;
    logic                     done_q;

    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_empty;
    logic                     fifo_full;

    logic start_ok;
    logic zero_size;
    logic req_hs;
    logic resp_ok;
    logic pop;
    logic last_req;
    logic last_col;
    logic frame_end;
    logic credit_ok;

    assign start_ok  = start && (state == IDLE);
    assign zero_size = (width == '0) || (height == '0);
    assign req_hs    = readValid && readReady;
    // Responses with nothing in flight are protocol errors and are discarded.
    assign resp_ok   = readDataValid && (outstanding != '0);
    assign pop       = pixelValid && pixelReady;
    assign last_req  = (req_idx == total_q - idx_t'(1));
    assign last_col  = (col == width_q - dim_t'(1));
    assign frame_end = pop && last_col && (row == height_q - dim_t'(1));

    // Counting queued plus in-flight words reserves a slot for every response,
    // so the FIFO can never be asked to take data it has no room for.
    assign credit_ok = (CRED_W'(fifo_count) + CRED_W'(outstanding)) < CRED_W'(FIFO_DEPTH);

    assign readValid   = (state == FETCH) && (outstanding < OUT_W'(MAX_OUTSTANDING)) && credit_ok;
    assign readAddress = base_q + ADDRESS_WIDTH'(req_idx);
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign pixelValid  = !fifo_empty;
    assign pixelFirst  = pixelValid && (col == '0) && (row == '0);
    assign pixelLast   = pixelValid && last_col;

    // NOTE: next_state gets its default before the case so no path through
    // this block leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start && !zero_size) next_state = FETCH;
            FETCH: if (req_hs && last_req && !LOOP_EN) next_state = DRAIN;
            DRAIN: if (frame_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            base_q      <= '0;
            width_q     <= '0;
            height_q    <= '0;
            total_q     <= '0;
            req_idx     <= '0;
            col         <= '0;
            row         <= '0;
            outstanding <= '0;
            done_q      <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (start_ok && zero_size) || frame_end;

            if (start_ok) begin
                base_q   <= frameAddress;
                width_q  <= width;
                height_q <= height;
                total_q  <= idx_t'(width) * idx_t'(height);
                req_idx  <= '0;
                col      <= '0;
                row      <= '0;
            end else if (req_hs) begin
                // Looping re-fetches the same held frame, so wrapping the index is the relatch.
                req_idx <= (LOOP_EN && last_req) ? '0 : req_idx + idx_t'(1);
            end

            if (pop) begin
                if (last_col) begin
                    col <= '0;
                    row <= (row == height_q - dim_t'(1)) ? '0 : row + dim_t'(1);
                end else begin
                    col <= col + dim_t'(1);
                end
            end

            case ({req_hs, resp_ok})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    scanout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (resp_ok),
        .pop   (pop),
        .din   (readData),
        .dout  (pixel),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule
